// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter
// Description : Shares one external word-wide memory port between the
//               instruction-cache refill path and the data-cache
//               refill/writeback path. Each grant moves one cache line as a
//               burst of BURST_LEN word beats. The data side has priority,
//               and a starvation counter forces an instruction grant after
//               STARVE_LIMIT consecutive data grants taken while the
//               instruction side was waiting.
//
// Ports       : clk_i / rst_i        clock, async active-low reset
//               icache_*             instruction line read requester
//               dcache_*             data line read/writeback requester
//               mem_*                single beat-level memory port
//               busy_o               arbiter is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
    parameter int BURST_LEN    = 4,   // words per line, power of two 2..16
    parameter int STARVE_LIMIT = 2    // data grants tolerated while I waits, 1..15
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        icache_req_i,
    input  logic [29:0] icache_addr_i,
    output logic [31:0] icache_rdata_o,
    output logic        icache_rvalid_o,
    output logic        icache_done_o,

    input  logic        dcache_req_i,
    input  logic        dcache_we_i,
    input  logic [29:0] dcache_addr_i,
    input  logic [31:0] dcache_wdata_i,
    output logic        dcache_wready_o,
    output logic [31:0] dcache_rdata_o,
    output logic        dcache_rvalid_o,
    output logic        dcache_done_o,

    output logic        mem_valid_o,
    output logic        mem_we_o,
    output logic [29:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i,

    output logic        busy_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_BEAT_W = $clog2(BURST_LEN);
    localparam int c_LINE_W = 30 - c_BEAT_W;

    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT  = c_BEAT_W'(BURST_LEN - 1);
    localparam logic [c_BEAT_W-1:0] c_BEAT_ONE   = c_BEAT_W'(1);
    localparam logic [3:0]          c_STARVE_MAX = 4'(STARVE_LIMIT);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_GNT_I = 2'd1;
    localparam logic [1:0] c_ST_GNT_D = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [c_BEAT_W-1:0] r_beat_cnt;
    logic [3:0]          r_starve_cnt;
    logic [c_LINE_W-1:0] r_line;        // line address captured at grant

    logic w_gnt_i;
    logic w_gnt_d;
    logic w_busy;
    logic w_beat;
    logic w_last;
    logic w_pick_i;
    logic w_pick_d;
    logic w_d_write;
    logic w_unused_addr_bits;

    // Word-in-line bits of the requester addresses are deliberately dropped:
    // bursts always start at beat 0 of the line.
    assign w_unused_addr_bits = ^{icache_addr_i[c_BEAT_W-1:0],
                                  dcache_addr_i[c_BEAT_W-1:0]};

    assign w_gnt_i = (r_state == c_ST_GNT_I);
    assign w_gnt_d = (r_state == c_ST_GNT_D);
    assign w_busy  = w_gnt_i | w_gnt_d;

    // A beat only exists while a grant is held; ready seen in IDLE is ignored.
    assign w_beat  = w_busy & mem_ready_i;
    assign w_last  = w_beat & (r_beat_cnt == c_LAST_BEAT);

    // Instruction side wins only when alone or when it has been starved for
    // the full limit; otherwise the data side takes the port.
    assign w_pick_i = icache_req_i & (~dcache_req_i | (r_starve_cnt >= c_STARVE_MAX));
    assign w_pick_d = dcache_req_i & ~w_pick_i;

    // ------------------------------------------------------------------------
    // Arbitration and burst sequencing
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= c_ST_IDLE;
            r_beat_cnt   <= '0;
            r_starve_cnt <= '0;
            r_line       <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_beat_cnt <= '0;
                    if (w_pick_d) begin
                        r_state <= c_ST_GNT_D;
                        r_line  <= dcache_addr_i[29:c_BEAT_W];
                        // Only grants taken over a waiting I request count.
                        if (icache_req_i && (r_starve_cnt < c_STARVE_MAX)) begin
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                        end
                    end else if (w_pick_i) begin
                        r_state      <= c_ST_GNT_I;
                        r_line       <= icache_addr_i[29:c_BEAT_W];
                        r_starve_cnt <= '0;
                    end
                end

                c_ST_GNT_I,
                c_ST_GNT_D: begin
                    // The owner keeps the port for exactly BURST_LEN beats,
                    // even if it drops its request part way through.
                    if (mem_ready_i) begin
                        if (r_beat_cnt == c_LAST_BEAT) begin
                            r_state    <= c_ST_IDLE;
                            r_beat_cnt <= '0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + c_BEAT_ONE;
                        end
                    end
                end

                default: begin
                    r_state    <= c_ST_IDLE;
                    r_beat_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output decode (state plus the current beat handshake)
    // ------------------------------------------------------------------------
    assign w_d_write = w_gnt_d & dcache_we_i;

    assign busy_o      = w_busy;
    assign mem_valid_o = w_busy;
    assign mem_we_o    = w_d_write;
    assign mem_addr_o  = w_busy ? {r_line, r_beat_cnt} : 30'd0;
    assign mem_wdata_o = w_d_write ? dcache_wdata_i : 32'd0;

    assign icache_rvalid_o = w_gnt_i & mem_ready_i;
    assign icache_rdata_o  = icache_rvalid_o ? mem_rdata_i : 32'd0;
    assign icache_done_o   = w_gnt_i & w_last;

    assign dcache_wready_o = w_d_write & mem_ready_i;
    assign dcache_rvalid_o = w_gnt_d & ~dcache_we_i & mem_ready_i;
    assign dcache_rdata_o  = dcache_rvalid_o ? mem_rdata_i : 32'd0;
    assign dcache_done_o   = w_gnt_d & w_last;

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_mem_arbiter
// Description : Self-checking bench for cache_mem_arbiter. Directed stimulus
//               pushes the expected memory beats into a scoreboard queue; a
//               negedge monitor pops and compares every completed beat and
//               checks that no side strobes appear outside beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

    localparam int BURST_LEN    = 4;
    localparam int STARVE_LIMIT = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        icache_req_i = 1'b0;
    logic [29:0] icache_addr_i = '0;
    logic [31:0] icache_rdata_o;
    logic        icache_rvalid_o;
    logic        icache_done_o;
    logic        dcache_req_i = 1'b0;
    logic        dcache_we_i = 1'b0;
    logic [29:0] dcache_addr_i = '0;
    logic [31:0] dcache_wdata_i = '0;
    logic        dcache_wready_o;
    logic [31:0] dcache_rdata_o;
    logic        dcache_rvalid_o;
    logic        dcache_done_o;
    logic        mem_valid_o;
    logic        mem_we_o;
    logic [29:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ready_i = 1'b0;
    logic [31:0] mem_rdata_i;
    logic        busy_o;

    always #5 clk_i = ~clk_i;

    cache_mem_arbiter #(
        .BURST_LEN    (BURST_LEN),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .icache_req_i    (icache_req_i),
        .icache_addr_i   (icache_addr_i),
        .icache_rdata_o  (icache_rdata_o),
        .icache_rvalid_o (icache_rvalid_o),
        .icache_done_o   (icache_done_o),
        .dcache_req_i    (dcache_req_i),
        .dcache_we_i     (dcache_we_i),
        .dcache_addr_i   (dcache_addr_i),
        .dcache_wdata_i  (dcache_wdata_i),
        .dcache_wready_o (dcache_wready_o),
        .dcache_rdata_o  (dcache_rdata_o),
        .dcache_rvalid_o (dcache_rvalid_o),
        .dcache_done_o   (dcache_done_o),
        .mem_valid_o     (mem_valid_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_ready_i     (mem_ready_i),
        .mem_rdata_i     (mem_rdata_i),
        .busy_o          (busy_o)
    );

    // Memory returns a value derived from the word address it is given.
    function automatic logic [31:0] mem_model(input logic [29:0] a);
        return 32'hC0DE_0000 ^ {2'b00, a};
    endfunction

    assign mem_rdata_i = mem_model(mem_addr_o);

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    typedef struct {
        bit          is_i;
        bit          we;
        logic [29:0] addr;
        logic [31:0] wdata;
        bit          last;
    } beat_t;

    beat_t sb[$];
    beat_t mon_e;
    int    n_pass  = 0;
    int    n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push_beats(input bit is_i, input bit we, input logic [29:0] base,
                              input logic [31:0] wbase, input int n, input bit full);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.is_i  = is_i;
            b.we    = we;
            b.addr  = base + 30'(k);
            b.wdata = we ? wbase + 32'(k) : 32'd0;
            b.last  = full && (k == BURST_LEN - 1);
            sb.push_back(b);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_i) begin
            if (mem_valid_o && mem_ready_i) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 64'(sb.size()), 64'd1);
                end else begin
                    mon_e = sb.pop_front();
                    check("beat_addr",     mem_addr_o,      mon_e.addr);
                    check("beat_we",       mem_we_o,        mon_e.we);
                    check("beat_wdata",    mem_wdata_o,     mon_e.wdata);
                    check("icache_rvalid", icache_rvalid_o, mon_e.is_i);
                    check("dcache_rvalid", dcache_rvalid_o, !mon_e.is_i && !mon_e.we);
                    check("dcache_wready", dcache_wready_o, !mon_e.is_i && mon_e.we);
                    check("icache_rdata",  icache_rdata_o,  mon_e.is_i ? mem_model(mon_e.addr) : 32'd0);
                    check("dcache_rdata",  dcache_rdata_o,
                          (!mon_e.is_i && !mon_e.we) ? mem_model(mon_e.addr) : 32'd0);
                    check("icache_done",   icache_done_o,   mon_e.is_i && mon_e.last);
                    check("dcache_done",   dcache_done_o,   !mon_e.is_i && mon_e.last);
                end
            end else begin
                check("quiet_strobes",
                      {icache_rvalid_o, dcache_rvalid_o, dcache_wready_o, icache_done_o, dcache_done_o},
                      5'b0);
            end
        end
    end

    // Bounded wait for a done pulse; sel 0 = icache, 1 = dcache.
    task automatic wait_done(input int sel, input int limit, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk_i);
            if ((sel == 0 && icache_done_o) || (sel == 1 && dcache_done_o)) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        bit seen;
        int idx;
        int cyc;
        int ndone;
        int ni;
        int gap;
        int nrv;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_mem_valid", mem_valid_o, 1'b0);
        check("rst_busy",      busy_o,      1'b0);
        check("rst_mem_addr",  mem_addr_o,  30'd0);
        check("rst_strobes",
              {icache_rvalid_o, dcache_rvalid_o, dcache_wready_o, icache_done_o, dcache_done_o, mem_we_o},
              6'b0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;

        // 1: icache refill from word 0x41, ready always high
        push_beats(1'b1, 1'b0, 30'h40, 32'd0, BURST_LEN, 1'b1);
        icache_req_i  = 1'b1;
        icache_addr_i = 30'h41;
        mem_ready_i   = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("t1_grant_latency", mem_valid_o, 1'b1);
        wait_done(0, 10, seen);
        check("t1_done_seen", seen, 1'b1);
        @(posedge clk_i); #1;
        icache_req_i = 1'b0;
        @(negedge clk_i);
        check("t1_idle_after", busy_o, 1'b0);

        // 2: dcache writeback at word 0x80, ready toggling
        @(posedge clk_i); #1;
        push_beats(1'b0, 1'b1, 30'h80, 32'hA0, BURST_LEN, 1'b1);
        dcache_req_i  = 1'b1;
        dcache_we_i   = 1'b1;
        dcache_addr_i = 30'h80;
        mem_ready_i   = 1'b0;
        idx  = 0;
        cyc  = -1;
        seen = 1'b0;
        dcache_wdata_i = 32'hA0;
        @(posedge clk_i); #1;
        for (int k = 0; k < 20; k++) begin
            mem_ready_i    = (k % 2 == 0);
            dcache_wdata_i = 32'hA0 + 32'(idx);
            @(negedge clk_i);
            if (busy_o) check("t2_we_held", mem_we_o, 1'b1);
            if (dcache_wready_o) idx++;
            if (dcache_done_o) begin
                seen = 1'b1;
                cyc  = k;
                break;
            end
            @(posedge clk_i); #1;
        end
        check("t2_done_seen",  seen, 1'b1);
        check("t2_done_cycle", 32'(cyc), 32'd6);
        check("t2_beats",      32'(idx), 32'd4);
        @(posedge clk_i); #1;
        dcache_req_i = 1'b0;
        dcache_we_i  = 1'b0;
        mem_ready_i  = 1'b0;
        @(posedge clk_i); #1;

        // 3: both held continuously -> D, D, I, D, D, I
        push_beats(1'b0, 1'b0, 30'h100, 32'd0, BURST_LEN, 1'b1);
        push_beats(1'b0, 1'b0, 30'h100, 32'd0, BURST_LEN, 1'b1);
        push_beats(1'b1, 1'b0, 30'h200, 32'd0, BURST_LEN, 1'b1);
        push_beats(1'b0, 1'b0, 30'h100, 32'd0, BURST_LEN, 1'b1);
        push_beats(1'b0, 1'b0, 30'h100, 32'd0, BURST_LEN, 1'b1);
        push_beats(1'b1, 1'b0, 30'h200, 32'd0, BURST_LEN, 1'b1);
        dcache_wdata_i = 32'hFFFF_FFFF;
        icache_req_i   = 1'b1;
        icache_addr_i  = 30'h202;
        dcache_req_i   = 1'b1;
        dcache_we_i    = 1'b0;
        dcache_addr_i  = 30'h103;
        mem_ready_i    = 1'b1;
        ndone = 0;
        ni    = 0;
        for (int c = 0; c < 100 && ndone < 6; c++) begin
            @(negedge clk_i);
            if (icache_done_o) begin ndone++; ni++; end
            if (dcache_done_o) ndone++;
        end
        check("t3_bursts",   32'(ndone), 32'd6);
        check("t3_i_bursts", 32'(ni),    32'd2);
        @(posedge clk_i); #1;
        icache_req_i = 1'b0;
        dcache_req_i = 1'b0;
        @(posedge clk_i); #1;

        // 4: simultaneous requests with starve count 0 -> dcache first
        push_beats(1'b0, 1'b0, 30'h300, 32'd0, BURST_LEN, 1'b1);
        push_beats(1'b1, 1'b0, 30'h400, 32'd0, BURST_LEN, 1'b1);
        icache_req_i  = 1'b1;
        icache_addr_i = 30'h400;
        dcache_req_i  = 1'b1;
        dcache_addr_i = 30'h300;
        wait_done(1, 20, seen);
        check("t4_d_done_seen", seen, 1'b1);
        @(posedge clk_i); #1;
        dcache_req_i = 1'b0;
        gap = 0;
        for (int g = 1; g <= 20; g++) begin
            @(negedge clk_i);
            if (icache_rvalid_o) begin
                gap = g;
                break;
            end
        end
        check("t4_i_gap", 32'(gap), 32'd2);
        wait_done(0, 20, seen);
        check("t4_i_done_seen", seen, 1'b1);
        @(posedge clk_i); #1;
        icache_req_i = 1'b0;
        @(posedge clk_i); #1;

        // 5: async reset on beat 2 of an icache burst
        push_beats(1'b1, 1'b0, 30'h40, 32'd0, 2, 1'b0);
        icache_req_i  = 1'b1;
        icache_addr_i = 30'h41;
        nrv = 0;
        for (int c = 0; c < 20 && nrv < 2; c++) begin
            @(negedge clk_i);
            if (icache_rvalid_o) nrv++;
        end
        check("t5_two_beats", 32'(nrv), 32'd2);
        @(posedge clk_i); #2;
        check("t5_pre_reset_addr", mem_addr_o, 30'h42);
        rst_i = 1'b0;
        #1;
        check("t5_rst_valid",  mem_valid_o,     1'b0);
        check("t5_rst_busy",   busy_o,          1'b0);
        check("t5_rst_addr",   mem_addr_o,      30'd0);
        check("t5_rst_rvalid", icache_rvalid_o, 1'b0);
        push_beats(1'b1, 1'b0, 30'h40, 32'd0, BURST_LEN, 1'b1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        wait_done(0, 20, seen);
        check("t5_done_seen", seen, 1'b1);
        @(posedge clk_i); #1;
        icache_req_i = 1'b0;
        @(posedge clk_i); #1;

        // 6: ready in IDLE without requests is ignored
        mem_ready_i = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            check("t6_idle_busy", busy_o,     1'b0);
            check("t6_idle_addr", mem_addr_o, 30'd0);
        end
        @(posedge clk_i); #1;
        push_beats(1'b1, 1'b0, 30'h44, 32'd0, BURST_LEN, 1'b1);
        icache_req_i  = 1'b1;
        icache_addr_i = 30'h47;
        wait_done(0, 20, seen);
        check("t6_done_seen", seen, 1'b1);
        @(posedge clk_i); #1;
        icache_req_i = 1'b0;
        mem_ready_i  = 1'b0;

        repeat (3) @(negedge clk_i);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
